// File: rtl/argmax_classifier_pkg.sv
// rtl/argmax_classifier_pkg.sv - shared FSM state type and sizing constants for the argmax classifier
//
// Purpose: single home for the classifier FSM encoding, the default class count
// and the width of the class-index output, so top level and bench agree.
package argmax_classifier_pkg;

  // Default number of scores in one inference vector.
  localparam int NUM_CLASSES = 10;

  // Width of the class index presented on out_class.
  localparam int CLASS_IDX_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SCAN   = 2'd1,
    ST_RESULT = 2'd2
  } state_t;

endpackage

// File: rtl/argmax_classifier.sv
// rtl/argmax_classifier.sv - streaming argmax over one vector of signed class scores
//
// Purpose: accepts a vector of signed scores, one per accepted transfer, and
// reports the index and value of the largest score. Ties keep the lower index.
// A vector closes on in_last or after num_classes scores, whichever comes first.
// out_error flags a vector whose length did not equal num_classes.
//
// Ports:
//   clk        - single clock, rising edge
//   rst_n      - asynchronous active-low reset
//   in_valid   - in_score/in_last valid this cycle
//   in_ready   - block accepts a score this cycle (low in RESULT and in reset)
//   in_score   - signed two's complement score of the current class
//   in_last    - final score of the vector
//   out_valid  - result held and valid
//   out_ready  - consumer accepts the result
//   out_class  - index of the maximum score
//   out_score  - maximum score
//   out_error  - vector length did not match num_classes
module argmax_classifier
  import argmax_classifier_pkg::*;
#(
  parameter int bitwidth    = 32,
  parameter int num_classes = NUM_CLASSES
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic signed [bitwidth-1:0] in_score,
  input  logic                       in_last,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [CLASS_IDX_W-1:0]     out_class,
  output logic signed [bitwidth-1:0] out_score,
  output logic                       out_error
);

  // Counter must be able to hold num_classes itself.
  localparam int              CNT_W    = $clog2(num_classes + 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(num_classes);
  localparam logic [CNT_W-1:0] ONE_CNT  = CNT_W'(1);

  state_t                     state_q, state_d;
  logic [CNT_W-1:0]           count_q, count_d;
  logic [CNT_W-1:0]           count_inc;
  logic signed [bitwidth-1:0] best_score_q, best_score_d;
  logic [CLASS_IDX_W-1:0]     best_idx_q, best_idx_d;
  logic                       error_q, error_d;
  logic                       accept;

  // in_ready is gated by rst_n so it reads low for the whole reset window.
  assign in_ready  = rst_n && (state_q != ST_RESULT);
  assign out_valid = (state_q == ST_RESULT);
  assign accept    = in_valid && in_ready;
  assign count_inc = count_q + ONE_CNT;

  assign out_class = best_idx_q;
  assign out_score = best_score_q;
  assign out_error = error_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q      <= '0;
      best_score_q <= '0;
      best_idx_q   <= '0;
      error_q      <= 1'b0;
    end else begin
      count_q      <= count_d;
      best_score_q <= best_score_d;
      best_idx_q   <= best_idx_d;
      error_q      <= error_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    best_score_d = best_score_q;
    best_idx_d   = best_idx_q;
    error_d      = error_q;

    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          // First score of a vector is the best so far by definition.
          best_score_d = in_score;
          best_idx_d   = '0;
          count_d      = ONE_CNT;
          if (in_last || (ONE_CNT == FULL_CNT)) begin
            // Closing without in_last means the length limit was hit.
            error_d = !in_last || (ONE_CNT != FULL_CNT);
            state_d = ST_RESULT;
          end else begin
            error_d = 1'b0;
            state_d = ST_SCAN;
          end
        end
      end

      ST_SCAN: begin
        if (accept) begin
          // Strict greater-than so an equal later score never displaces an earlier one.
          if (in_score > best_score_q) begin
            best_score_d = in_score;
            best_idx_d   = CLASS_IDX_W'(count_q);
          end
          count_d = count_inc;
          if (in_last || (count_inc == FULL_CNT)) begin
            error_d = !in_last || (count_inc != FULL_CNT);
            state_d = ST_RESULT;
          end
        end
      end

      ST_RESULT: begin
        if (out_ready) begin
          count_d = '0;
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_argmax_classifier.sv
// tb/tb_argmax_classifier.sv - self-checking bench for argmax_classifier
module tb_argmax_classifier;
  import argmax_classifier_pkg::*;

  localparam int W = 32;

  logic                clk       = 1'b0;
  logic                rst_n     = 1'b0;
  logic                in_valid  = 1'b0;
  logic                in_last   = 1'b0;
  logic                out_ready = 1'b0;
  logic signed [W-1:0] in_score  = '0;
  logic                in_ready;
  logic                out_valid;
  logic                out_error;
  logic [3:0]          out_class;
  logic signed [W-1:0] out_score;

  int n_checks = 0;
  int n_errors = 0;

  logic signed [W-1:0] vec_q[$];
  logic [3:0]          exp_cls;
  logic signed [W-1:0] exp_score;
  logic                exp_err;
  logic [3:0]          got_cls;
  logic signed [W-1:0] got_score;
  logic                got_err;

  argmax_classifier #(
    .bitwidth    (W),
    .num_classes (NUM_CLASSES)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_score  (in_score),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_class (out_class),
    .out_score (out_score),
    .out_error (out_error)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  // Reference: argmax with first-occurrence tie rule; error when the vector
  // was not closed by in_last exactly at NUM_CLASSES scores.
  task automatic model(input bit has_last);
    exp_cls   = 4'd0;
    exp_score = vec_q[0];
    for (int i = 1; i < vec_q.size(); i++) begin
      if (vec_q[i] > exp_score) begin
        exp_score = vec_q[i];
        exp_cls   = 4'(i);
      end
    end
    exp_err = !has_last || (vec_q.size() != NUM_CLASSES);
  endtask

  task automatic fill_random(input int n, input bit narrow);
    int v;
    vec_q.delete();
    for (int i = 0; i < n; i++) begin
      if (narrow) v = int'($urandom_range(0, 6)) - 3;
      else        v = int'($urandom());
      vec_q.push_back(v);
    end
  endtask

  // Drives vec_q; returns at the negedge following the final transfer.
  task automatic drive_vector(input bit gaps, input bit mark_last);
    int n;
    int waited;
    int g;
    n = vec_q.size();
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (gaps) begin
        g = int'($urandom_range(0, 3));
        in_valid = 1'b0;
        repeat (g) @(negedge clk);
      end
      in_valid = 1'b1;
      in_score = vec_q[i];
      in_last  = mark_last && (i == n - 1);
      waited = 0;
      while (!in_ready && waited < 20) begin
        @(negedge clk);
        waited++;
      end
      if (!in_ready) begin
        n_checks++;
        n_errors++;
        $display("FAIL in_ready_timeout: in_ready=%0b required 1", in_ready);
      end
      @(posedge clk);
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic take_result();
    int waited;
    waited = 0;
    while (!out_valid && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (!out_valid) begin
      n_checks++;
      n_errors++;
      $display("FAIL out_valid_timeout: out_valid=%0b required 1", out_valid);
    end
    got_cls   = out_class;
    got_score = out_score;
    got_err   = out_error;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    n_checks++;
    if (in_ready !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_in_ready: got %0b required 0", in_ready);
    end
    n_checks++;
    if (out_valid !== 1'b0 || out_class !== 4'd0 || out_score !== '0 || out_error !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_outputs: got valid=%0b class=%0d score=%0d err=%0b required 0/0/0/0",
               out_valid, out_class, out_score, out_error);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL reset_release_in_ready: got %0b required 1", in_ready);
    end
  endtask

  task automatic test_directed_tie();
    vec_q = '{32'sd5, -32'sd3, 32'sd12, 32'sd7, 32'sd12, 32'sd0, -32'sd1, 32'sd4, 32'sd2, 32'sd11};
    drive_vector(1'b0, 1'b1);
    n_checks++;
    if (out_valid !== 1'b1) begin
      n_errors++;
      $display("FAIL tie_latency: out_valid=%0b required 1", out_valid);
    end
    take_result();
    n_checks++;
    if (got_cls !== 4'd2 || got_score !== 32'sd12 || got_err !== 1'b0) begin
      n_errors++;
      $display("FAIL tie_result: got class=%0d score=%0d err=%0b required 2/12/0", got_cls, got_score, got_err);
    end
  endtask

  task automatic test_min_values();
    vec_q.delete();
    for (int i = 0; i < NUM_CLASSES; i++) vec_q.push_back(32'sh80000000);
    drive_vector(1'b0, 1'b1);
    take_result();
    n_checks++;
    if (got_cls !== 4'd0 || got_score !== 32'sh80000000 || got_err !== 1'b0) begin
      n_errors++;
      $display("FAIL min_values: got class=%0d score=%0d err=%0b required 0/-2147483648/0", got_cls, got_score, got_err);
    end
  endtask

  task automatic test_short_vector();
    vec_q = '{32'sd3, -32'sd7, 32'sd1, 32'sd8, 32'sd9, -32'sd2};
    drive_vector(1'b0, 1'b1);
    n_checks++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
      n_errors++;
      $display("FAIL short_latency: out_valid=%0b in_ready=%0b required 1/0", out_valid, in_ready);
    end
    take_result();
    n_checks++;
    if (got_cls !== 4'd4 || got_score !== 32'sd9 || got_err !== 1'b1) begin
      n_errors++;
      $display("FAIL short_result: got class=%0d score=%0d err=%0b required 4/9/1", got_cls, got_score, got_err);
    end
  endtask

  task automatic test_overlong();
    fill_random(NUM_CLASSES, 1'b1);
    model(1'b0);
    drive_vector(1'b1, 1'b0);
    n_checks++;
    if (out_valid !== 1'b1) begin
      n_errors++;
      $display("FAIL overlong_close: out_valid=%0b required 1", out_valid);
    end
    take_result();
    n_checks++;
    if (got_cls !== exp_cls || got_score !== exp_score || got_err !== exp_err) begin
      n_errors++;
      $display("FAIL overlong_result: got class=%0d score=%0d err=%0b required %0d/%0d/%0b",
               got_cls, got_score, got_err, exp_cls, exp_score, exp_err);
    end
  endtask

  task automatic test_stall();
    int bad;
    fill_random(NUM_CLASSES, 1'b0);
    model(1'b1);
    drive_vector(1'b1, 1'b1);
    bad = 0;
    for (int c = 0; c < 5; c++) begin
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_class !== exp_cls ||
          out_score !== exp_score || out_error !== exp_err) bad++;
      @(negedge clk);
    end
    n_checks++;
    if (bad != 0) begin
      n_errors++;
      $display("FAIL stall_hold: %0d unstable cycles, last class=%0d score=%0d err=%0b required %0d/%0d/%0b",
               bad, out_class, out_score, out_error, exp_cls, exp_score, exp_err);
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    bad = 0;
    for (int c = 0; c < 4; c++) begin
      if (out_valid !== 1'b0) bad++;
      @(negedge clk);
    end
    n_checks++;
    if (bad != 0) begin
      n_errors++;
      $display("FAIL stall_single_handshake: out_valid high %0d cycles after handshake, required 0", bad);
    end
  endtask

  task automatic test_reset_midvector();
    int bad;
    fill_random(4, 1'b0);
    drive_vector(1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL midvec_reset: in_ready=%0b out_valid=%0b required 0/0", in_ready, out_valid);
    end
    @(negedge clk);
    rst_n = 1'b1;
    vec_q.delete();
    for (int i = 1; i <= 10; i++) vec_q.push_back(i);
    drive_vector(1'b0, 1'b1);
    take_result();
    n_checks++;
    if (got_cls !== 4'd9 || got_score !== 32'sd10 || got_err !== 1'b0) begin
      n_errors++;
      $display("FAIL midvec_after: got class=%0d score=%0d err=%0b required 9/10/0", got_cls, got_score, got_err);
    end
    // Reset while a result is pending must drop it.
    fill_random(NUM_CLASSES, 1'b0);
    drive_vector(1'b0, 1'b1);
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || out_class !== 4'd0 || out_score !== '0 || out_error !== 1'b0) begin
      n_errors++;
      $display("FAIL result_reset: got valid=%0b class=%0d score=%0d err=%0b required 0/0/0/0",
               out_valid, out_class, out_score, out_error);
    end
    @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (out_valid !== 1'b0) bad++;
    end
    n_checks++;
    if (bad != 0) begin
      n_errors++;
      $display("FAIL result_reset_no_output: out_valid high %0d cycles, required 0", bad);
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0]          a_cls;
    logic signed [W-1:0] a_score;
    logic                a_err;
    out_ready = 1'b1;
    fill_random(NUM_CLASSES, 1'b1);
    model(1'b1);
    a_cls = exp_cls; a_score = exp_score; a_err = exp_err;
    drive_vector(1'b0, 1'b1);
    n_checks++;
    if (out_valid !== 1'b1 || out_class !== a_cls || out_score !== a_score || out_error !== a_err) begin
      n_errors++;
      $display("FAIL b2b_first: got valid=%0b class=%0d score=%0d err=%0b required 1/%0d/%0d/%0b",
               out_valid, out_class, out_score, out_error, a_cls, a_score, a_err);
    end
    fill_random(int'($urandom_range(1, NUM_CLASSES)), 1'b0);
    model(1'b1);
    drive_vector(1'b0, 1'b1);
    n_checks++;
    if (out_valid !== 1'b1 || out_class !== exp_cls || out_score !== exp_score || out_error !== exp_err) begin
      n_errors++;
      $display("FAIL b2b_second: got valid=%0b class=%0d score=%0d err=%0b required 1/%0d/%0d/%0b",
               out_valid, out_class, out_score, out_error, exp_cls, exp_score, exp_err);
    end
    @(negedge clk);
    out_ready = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL b2b_no_duplicate: out_valid=%0b required 0", out_valid);
    end
  endtask

  task automatic test_random();
    for (int t = 0; t < 24; t++) begin
      fill_random(int'($urandom_range(1, NUM_CLASSES)), 1'($urandom_range(0, 1)));
      model(1'b1);
      drive_vector(1'b1, 1'b1);
      n_checks++;
      if (out_valid !== 1'b1) begin
        n_errors++;
        $display("FAIL random_latency[%0d]: out_valid=%0b required 1", t, out_valid);
      end
      take_result();
      n_checks++;
      if (got_cls !== exp_cls || got_score !== exp_score || got_err !== exp_err) begin
        n_errors++;
        $display("FAIL random_result[%0d]: got class=%0d score=%0d err=%0b required %0d/%0d/%0b",
                 t, got_cls, got_score, got_err, exp_cls, exp_score, exp_err);
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed_tie();
    test_min_values();
    test_short_vector();
    test_overlong();
    test_stall();
    test_reset_midvector();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/argmax_classifier.md
ARGMAX_CLASSIFIER -- requirements
Module: argmax_classifier

Interface
REQ-001 Parameter: bitwidth, 32, width of each signed class score.
REQ-002 Parameter: num_classes, 10, scores per inference vector.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset is asynchronous and active-low.
REQ-005 in_valid  input  1  in_score/in_last are valid this cycle.
REQ-006 in_ready  output  1  block accepts a score this cycle.
REQ-007 in_score  input  bitwidth  signed score of the current class, two's complement.
REQ-008 in_last  input  1  marks the final score of a vector.
REQ-009 out_valid  output  1  result held and valid.
REQ-010 out_ready  input  1  consumer accepts the result.
REQ-011 out_class  output  4  index (0..num_classes-1) of the maximum score.
REQ-012 out_score  output  bitwidth  signed maximum score.
REQ-013 out_error  output  1  in_last position did not match num_classes.

Function
REQ-014 Input transfer SHALL occur only when in_valid and in_ready are both high on a rising edge.
REQ-015 FSM SHALL have states IDLE, SCAN, RESULT.
REQ-016 IDLE: in_ready=1; first accepted score loads best_score=in_score, best_idx=0, count=1; next state SCAN, or RESULT if in_last.
REQ-017 SCAN: in_ready=1; each accepted score is compared signed against best_score; strictly greater replaces best_score and best_idx=count; count increments.
REQ-018 Ties SHALL keep the lower index (strict > comparison only).
REQ-019 Accepted score with in_last=1 SHALL move FSM to RESULT on the same edge, including the comparison with that score.
REQ-020 out_error SHALL be set when in_last arrives with total accepted count != num_classes.
REQ-021 If num_classes scores are accepted without in_last, the vector SHALL close after the num_classes-th score with out_error=1.
REQ-022 RESULT: in_ready=0, out_valid=1; out_class, out_score, out_error stable until out_valid&&out_ready.
REQ-023 On output handshake FSM SHALL return to IDLE; out_valid falls the next cycle; no back-to-back bypass (in_ready low in RESULT).
REQ-024 Latency: out_valid SHALL rise the cycle after the in_last (or num_classes-th) transfer.
REQ-025 in_valid low SHALL stall SCAN without changing state or count.
REQ-026 out_class, out_score, out_error SHALL be driven from registers only; in_ready and out_valid decode directly from state.
REQ-027 Comparison SHALL be full bitwidth signed; no truncation or saturation.

Reset
REQ-028 rst_n low SHALL immediately force IDLE, count=0, best_score=0, best_idx=0.
REQ-029 Output reset values: in_ready=0 while rst_n low, 1 after release; out_valid=0, out_class=0, out_score=0, out_error=0.
REQ-030 Reset mid-vector or mid-RESULT SHALL discard the partial/pending result; no output handshake follows.

Structure
REQ-031 Shared package SHALL hold the FSM state enum, NUM_CLASSES=10 constant, and class-index width (4).
REQ-032 No sub-module; comparator and counter remain inline.

Verification
REQ-033 Scores 0..9 = {5,-3,12,7,12,0,-1,4,2,11}, in_last on 10th -> out_class=2, out_score=12, out_error=0 (tie keeps index 2).
REQ-034 All ten scores = -2147483648 -> out_class=0, out_score=-2147483648, out_error=0.
REQ-035 in_last on 6th score, max 9 at index 4 -> out_class=4, out_score=9, out_error=1, out_valid one cycle after transfer.
REQ-036 Random in_valid gaps and out_ready held low 5 cycles -> outputs stable while stalled, in_ready=0 throughout RESULT, single handshake.
REQ-037 rst_n asserted after 4 scores, then full vector {1,2,...,10} -> out_class=9, out_score=10; no result from aborted vector.
REQ-038 Two vectors back-to-back with out_ready=1 -> two results, each in order, no lost or duplicated vector.
